// File: rtl/inst_fetch_mem.sv
// inst_fetch_mem: byte-loadable instruction memory with a one-word-per-cycle fetch port,
// per-word loaded bits, and a valid/ready response stage that supports flush.
module inst_fetch_mem #(
   parameter int          ADDR_W   = 32,
   parameter int          DEPTH    = 1024,
   parameter logic [31:0] NOP_INST = 32'h00000013
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_ready,
   output logic              rsp_valid,
   output logic [31:0]       rsp_inst,
   output logic              rsp_err,
   input  logic              rsp_ready,
   input  logic              flush,
   input  logic              ld_we,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [7:0]        ld_data
);
   localparam int AW = $clog2(DEPTH);
   localparam int WN = DEPTH / 4;
   localparam int WW = (AW > 2) ? AW - 2 : 1;

   logic [7:0]    mem_q [DEPTH];
   logic [WN-1:0] loaded_q, loaded_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic          rsp_err_q, rsp_err_d;
   logic [31:0]   rsp_inst_q, rsp_inst_d;
   logic [AW-1:0] fa, la;
   logic [WW-1:0] fw, lw;
   logic          accept, ld_ok, f_err;
   logic [31:0]   word;

   assign fa = fetch_addr[AW-1:0];
   assign la = ld_addr[AW-1:0];
   assign fw = WW'(fa >> 2);
   assign lw = WW'(la >> 2);
   assign ld_ok = ld_we && ((ld_addr >> AW) == '0);
   // For aligned addresses, "above DEPTH-4" is the same as any bit at or above log2(DEPTH) set.
   assign f_err = (fa[1:0] != 2'b00) || ((fetch_addr >> AW) != '0);
   assign word = {mem_q[fa | AW'(3)], mem_q[fa | AW'(2)], mem_q[fa | AW'(1)], mem_q[fa]};
   assign fetch_ready = (!rsp_valid_q || rsp_ready) && !flush;
   assign accept = fetch_req && fetch_ready;

   always_comb begin
      loaded_d = loaded_q;
      if (ld_ok) loaded_d[lw] = 1'b1;
      rsp_valid_d = !flush && (accept || (rsp_valid_q && !rsp_ready));
      rsp_err_d = accept ? f_err : rsp_err_q;
      rsp_inst_d = accept ? ((f_err || !loaded_q[fw]) ? NOP_INST : word) : rsp_inst_q;
   end

   // Byte storage is not reset; reading mem_q here gives read-before-write on a same-word load.
   always_ff @(posedge clk) begin
      if (ld_ok) mem_q[la] <= ld_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         loaded_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_inst_q  <= NOP_INST;
      end else begin
         loaded_q    <= loaded_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_inst_q  <= rsp_inst_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_inst  = rsp_inst_q;
endmodule

// File: tb/tb_inst_fetch_mem.sv
// tb_inst_fetch_mem: directed vector table plus randomized traffic against a transaction-level model.
module tb_inst_fetch_mem;
   localparam int          DEPTH = 1024;
   localparam logic [31:0] NOP   = 32'h00000013;

   logic        clk, rst_n, fetch_req, fetch_ready, rsp_valid, rsp_err, rsp_ready, flush, ld_we;
   logic [31:0] fetch_addr, rsp_inst, ld_addr;
   logic [7:0]  ld_data;

   inst_fetch_mem #(.ADDR_W(32), .DEPTH(DEPTH), .NOP_INST(NOP)) dut (
      .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
      .fetch_ready(fetch_ready), .rsp_valid(rsp_valid), .rsp_inst(rsp_inst), .rsp_err(rsp_err),
      .rsp_ready(rsp_ready), .flush(flush), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;

   logic [7:0]  m_mem [DEPTH];
   logic        m_ld [DEPTH/4];
   logic        m_valid, m_err;
   logic [31:0] m_inst;

   typedef struct {
      logic        req;
      logic [31:0] fa;
      logic        rdy;
      logic        fl;
      logic        we;
      logic [31:0] la;
      logic [7:0]  ld;
      logic        ev;
      logic [31:0] ei;
      logic        ee;
   } vec_t;
   vec_t tbl [$];

   function automatic vec_t v(logic req, logic [31:0] fa, logic rdy, logic fl, logic we,
                              logic [31:0] la, logic [7:0] ld, logic ev, logic [31:0] ei, logic ee);
      vec_t r;
      r.req = req; r.fa = fa; r.rdy = rdy; r.fl = fl; r.we = we;
      r.la = la; r.ld = ld; r.ev = ev; r.ei = ei; r.ee = ee;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      m_valid = 1'b0;
      m_err   = 1'b0;
      m_inst  = NOP;
      for (int i = 0; i < DEPTH/4; i++) m_ld[i] = 1'b0;
   endtask

   // One clock cycle: drive at the negedge, check fetch_ready, advance the model, check after the edge.
   task automatic step(input logic req, input logic [31:0] fa, input logic rdy, input logic fl,
                       input logic we, input logic [31:0] la, input logic [7:0] ld);
      logic exp_fr, acc, e;
      fetch_req = req; fetch_addr = fa; rsp_ready = rdy; flush = fl;
      ld_we = we; ld_addr = la; ld_data = ld;
      #1;
      exp_fr = (!m_valid || rdy) && !fl;
      chk("fetch_ready", {31'd0, fetch_ready}, {31'd0, exp_fr});
      acc = req && exp_fr;
      if (acc) begin
         e = (fa % 4 != 0) || (fa > DEPTH - 4);
         m_err = e;
         m_inst = (e || !m_ld[fa / 4]) ? NOP : {m_mem[fa+3], m_mem[fa+2], m_mem[fa+1], m_mem[fa]};
      end
      m_valid = !fl && (acc || (m_valid && !rdy));
      if (we && la < DEPTH) begin
         m_mem[la] = ld;
         m_ld[la / 4] = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_valid});
      if (m_valid) begin
         chk("rsp_inst", rsp_inst, m_inst);
         chk("rsp_err", {31'd0, rsp_err}, {31'd0, m_err});
      end
   endtask

   initial begin
      logic [31:0] fa, la;
      int k;
      rst_n = 1'b0; fetch_req = 0; fetch_addr = 0; rsp_ready = 0; flush = 0;
      ld_we = 0; ld_addr = 0; ld_data = 0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("reset rsp_err", {31'd0, rsp_err}, 32'd0);
      chk("reset rsp_inst", rsp_inst, NOP);
      chk("reset fetch_ready", {31'd0, fetch_ready}, 32'd1);
      flush = 1'b1;
      #1 chk("reset flush blocks ready", {31'd0, fetch_ready}, 32'd0);
      flush = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      //          req  fa     rdy fl we la    ld     ev  ei            ee
      tbl.push_back(v(1, 8,    1, 0, 0, 0,    8'h00, 1, 32'h00000013, 0));
      tbl.push_back(v(0, 0,    1, 0, 1, 0,    8'h93, 0, 0,            0));
      tbl.push_back(v(0, 0,    1, 0, 1, 1,    8'h01, 0, 0,            0));
      tbl.push_back(v(0, 0,    1, 0, 1, 2,    8'h10, 0, 0,            0));
      tbl.push_back(v(0, 0,    1, 0, 1, 3,    8'h00, 0, 0,            0));
      tbl.push_back(v(0, 0,    1, 0, 1, 1024, 8'hAA, 0, 0,            0));
      tbl.push_back(v(1, 0,    1, 0, 0, 0,    8'h00, 1, 32'h00100193, 0));
      tbl.push_back(v(1, 6,    1, 0, 0, 0,    8'h00, 1, 32'h00000013, 1));
      tbl.push_back(v(1, 1024, 1, 0, 0, 0,    8'h00, 1, 32'h00000013, 1));
      tbl.push_back(v(1, 1020, 1, 0, 0, 0,    8'h00, 1, 32'h00000013, 0));
      tbl.push_back(v(1, 1021, 1, 0, 0, 0,    8'h00, 1, 32'h00000013, 1));
      tbl.push_back(v(1, 0,    1, 0, 0, 0,    8'h00, 1, 32'h00100193, 0));
      tbl.push_back(v(1, 4,    0, 0, 0, 0,    8'h00, 1, 32'h00100193, 0));
      tbl.push_back(v(1, 4,    0, 0, 0, 0,    8'h00, 1, 32'h00100193, 0));
      tbl.push_back(v(1, 4,    0, 0, 0, 0,    8'h00, 1, 32'h00100193, 0));
      tbl.push_back(v(1, 4,    1, 0, 0, 0,    8'h00, 1, 32'h00000013, 0));
      tbl.push_back(v(0, 0,    1, 0, 0, 0,    8'h00, 0, 0,            0));
      tbl.push_back(v(1, 0,    1, 0, 0, 0,    8'h00, 1, 32'h00100193, 0));
      tbl.push_back(v(1, 0,    1, 1, 0, 0,    8'h00, 0, 0,            0));
      tbl.push_back(v(0, 0,    1, 0, 0, 0,    8'h00, 0, 0,            0));
      tbl.push_back(v(1, 0,    1, 0, 1, 0,    8'hFF, 1, 32'h00100193, 0));
      tbl.push_back(v(1, 0,    1, 0, 0, 0,    8'h00, 1, 32'h001001FF, 0));
      tbl.push_back(v(1, 48,   1, 0, 1, 48,   8'h11, 1, 32'h00000013, 0));
      tbl.push_back(v(0, 0,    1, 1, 1, 49,   8'h22, 0, 0,            0));
      tbl.push_back(v(0, 0,    1, 0, 1, 50,   8'h33, 0, 0,            0));
      tbl.push_back(v(0, 0,    1, 0, 1, 51,   8'h44, 0, 0,            0));
      tbl.push_back(v(1, 48,   1, 0, 0, 0,    8'h00, 1, 32'h44332211, 0));
      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].req, tbl[i].fa, tbl[i].rdy, tbl[i].fl, tbl[i].we, tbl[i].la, tbl[i].ld);
         chk($sformatf("vec%0d valid", i), {31'd0, rsp_valid}, {31'd0, tbl[i].ev});
         if (tbl[i].ev) begin
            chk($sformatf("vec%0d inst", i), rsp_inst, tbl[i].ei);
            chk($sformatf("vec%0d err", i), {31'd0, rsp_err}, {31'd0, tbl[i].ee});
         end
      end

      // Asynchronous reset in the middle of a held response.
      step(1, 0, 0, 0, 0, 0, 8'h00);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("async reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("async reset rsp_inst", rsp_inst, NOP);
      chk("async reset fetch_ready", {31'd0, fetch_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      step(1, 0, 1, 0, 0, 0, 8'h00);
      chk("post-reset fetch 0 inst", rsp_inst, NOP);
      chk("post-reset fetch 0 err", {31'd0, rsp_err}, 32'd0);

      // Randomized traffic: fully load a 64-byte window, then mix fetches, loads, stalls and flushes.
      for (int i = 0; i < 64; i++) step(0, 0, 1, 0, 1, i, 8'($urandom));
      for (int n = 0; n < 3000; n++) begin
         k = int'($urandom_range(0, 9));
         fa = k < 5 ? 4 * $urandom_range(0, 15) :
              k < 6 ? $urandom_range(0, 63) :
              k < 8 ? 4 * $urandom_range(16, 255) : $urandom_range(1016, 1100);
         la = ($urandom_range(0, 3) == 0) ? 1024 + $urandom_range(0, 100) : $urandom_range(0, 63);
         step($urandom_range(0, 9) < 7, fa, $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
              $urandom_range(0, 1) == 1, la, 8'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
